// File: rtl/aes_host_if_pkg.sv
// Shared types and sizes for the AES host interface.
// Block layout: word 0 of a frame occupies bits [127:96], word 3 bits [31:0].
package aes_host_if_pkg;

    localparam int WORDS_PER_BLOCK = 4;
    localparam int WORD_W          = 32;
    localparam int BLOCK_W         = WORDS_PER_BLOCK * WORD_W;

    typedef enum logic [1:0] {
        CMD_KEY  = 2'd0,
        CMD_ENC  = 2'd1,
        CMD_DEC  = 2'd2,
        CMD_RSVD = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ISSUE  = 3'd2,
        ST_START  = 3'd3,
        ST_WAIT   = 3'd4,
        ST_UNLOAD = 3'd5
    } state_e;

endpackage

// File: rtl/aes_host_if_shreg.sv
// aes_block_shreg: 128-bit assembly register shared by operand packing and
// result unpacking. Words enter at the bottom and leave from the top, so the
// first word in / first word out always sits at bits [127:96].
// Priority: parallel load > shift-in > shift-out.
module aes_block_shreg
    import aes_host_if_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic               shift_in_en,
    input  logic               shift_out_en,
    input  logic [BLOCK_W-1:0] load_data,
    input  logic [WORD_W-1:0]  word_in,
    output logic [BLOCK_W-1:0] block,
    output logic [WORD_W-1:0]  word_out
);

    logic [BLOCK_W-1:0] blk_q;
    logic [BLOCK_W-1:0] blk_d;

    // next value: load a core result, pack an input word, or drain an output word
    always_comb begin
        blk_d = blk_q;
        if (load_en) begin
            blk_d = load_data;
        end else if (shift_in_en) begin
            blk_d = {blk_q[BLOCK_W-WORD_W-1:0], word_in};
        end else if (shift_out_en) begin
            blk_d = {blk_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    // register with synchronous clear
    always_ff @(posedge clk) begin
        if (reset) begin
            blk_q <= '0;
        end else begin
            blk_q <= blk_d;
        end
    end

    assign block    = blk_q;
    assign word_out = blk_q[BLOCK_W-1 -: WORD_W];

endmodule

// File: rtl/aes_host_if.sv
// aes_host_if: word-serial front end for the AES core. Packs 4-beat command
// frames into a 128-bit block, sequences the core's set/start strobes, waits
// OP_CYCLES, then streams the 128-bit result back out in 4 beats.
// Optional feature macro: AES_HOST_IF_KEY_GUARD_EN rejects encrypt/decrypt
// frames until a key has been loaded since reset.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for the first beat of a frame
// LOAD   | collecting beats 2..4 into the assembly register
// ISSUE  | one set strobe (or err for a rejected frame)
// START  | one start strobe, wait counter loaded with OP_CYCLES
// WAIT   | counting down; result captured on the last cycle
// UNLOAD | presenting the result, one word per output handshake
module aes_host_if
    import aes_host_if_pkg::*;
#(
    parameter int OP_CYCLES = 12
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic [1:0]         s_cmd,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WORD_W-1:0]  m_data,
    output logic               m_last,
    output logic               busy,
    output logic               err,
    output logic               set_key,
    output logic               set_plain_text,
    output logic               set_cipher_text,
    output logic               start_enc,
    output logic               start_dec,
    output logic [BLOCK_W-1:0] key,
    output logic [BLOCK_W-1:0] plain_text_in,
    output logic [BLOCK_W-1:0] cipher_text_in,
    input  logic [BLOCK_W-1:0] cipher_text_out,
    input  logic [BLOCK_W-1:0] plain_text_out
);

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_LOAD   = ST_LOAD;
    localparam logic [2:0] S_ISSUE  = ST_ISSUE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_WAIT   = ST_WAIT;
    localparam logic [2:0] S_UNLOAD = ST_UNLOAD;

    localparam int                WAIT_W    = $clog2(OP_CYCLES + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(OP_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

    logic [2:0]        state_q, state_d;
    cmd_e              cmd_q, cmd_d;
    logic [1:0]        beat_q, beat_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              s_ready_q, s_ready_d;

    logic               accept;
    logic               key_missing;
    logic               sh_load, sh_in, sh_out;
    logic [BLOCK_W-1:0] sh_load_data;
    logic [BLOCK_W-1:0] sh_block;

    assign accept = s_valid && s_ready_q;

`ifdef AES_HOST_IF_KEY_GUARD_EN
    logic key_loaded_q, key_loaded_d;

    // remember that a key has been handed to the core since reset
    always_comb begin
        key_loaded_d = key_loaded_q;
        if (state_q == S_ISSUE && cmd_q == CMD_KEY) begin
            key_loaded_d = 1'b1;
        end
    end

    // key history flop
    always_ff @(posedge clk) begin
        if (reset) begin
            key_loaded_q <= 1'b0;
        end else begin
            key_loaded_q <= key_loaded_d;
        end
    end

    assign key_missing = !key_loaded_q;
`else
    assign key_missing = 1'b0;
`endif

    // sequencing: next state, counters, register controls and core strobes
    always_comb begin
        state_d         = state_q;
        cmd_d           = cmd_q;
        beat_d          = beat_q;
        wait_d          = wait_q;
        sh_load         = 1'b0;
        sh_in           = 1'b0;
        sh_out          = 1'b0;
        sh_load_data    = cipher_text_out;
        set_key         = 1'b0;
        set_plain_text  = 1'b0;
        set_cipher_text = 1'b0;
        start_enc       = 1'b0;
        start_dec       = 1'b0;
        err             = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cmd_d   = cmd_e'(s_cmd);
                    sh_in   = 1'b1;
                    beat_d  = 2'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    sh_in  = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                case (cmd_q)
                    CMD_KEY: begin
                        set_key = 1'b1;
                        state_d = S_IDLE;
                    end
                    CMD_ENC: begin
                        if (key_missing) begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            set_plain_text = 1'b1;
                            state_d        = S_START;
                        end
                    end
                    CMD_DEC: begin
                        if (key_missing) begin
                            err     = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            set_cipher_text = 1'b1;
                            state_d         = S_START;
                        end
                    end
                    default: begin
                        err     = 1'b1;
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_START: begin
                start_enc = (cmd_q == CMD_ENC);
                start_dec = (cmd_q == CMD_DEC);
                wait_d    = WAIT_LOAD;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                wait_d = wait_q - WAIT_ONE;
                if (wait_q == WAIT_ONE) begin
                    sh_load      = 1'b1;
                    sh_load_data = (cmd_q == CMD_ENC) ? cipher_text_out : plain_text_out;
                    state_d      = S_UNLOAD;
                end
            end
            S_UNLOAD: begin
                if (m_ready) begin
                    sh_out = 1'b1;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // a strobe must never reach the core while reset is being applied
        if (reset) begin
            set_key         = 1'b0;
            set_plain_text  = 1'b0;
            set_cipher_text = 1'b0;
            start_enc       = 1'b0;
            start_dec       = 1'b0;
            err             = 1'b0;
        end

        s_ready_d = (state_d == S_IDLE) || (state_d == S_LOAD);
    end

    // state and counter registers; s_ready is registered so it stays low through reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cmd_q     <= CMD_KEY;
            beat_q    <= 2'd0;
            wait_q    <= '0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            s_ready_q <= s_ready_d;
        end
    end

    aes_block_shreg u_shreg (
        .clk          (clk),
        .reset        (reset),
        .load_en      (sh_load),
        .shift_in_en  (sh_in),
        .shift_out_en (sh_out),
        .load_data    (sh_load_data),
        .word_in      (s_data),
        .block        (sh_block),
        .word_out     (m_data)
    );

    assign s_ready        = s_ready_q;
    assign m_valid        = (state_q == S_UNLOAD);
    assign m_last         = (state_q == S_UNLOAD) && (beat_q == 2'd3);
    assign busy           = (state_q != S_IDLE);
    assign key            = sh_block;
    assign plain_text_in  = sh_block;
    assign cipher_text_in = sh_block;

endmodule

// File: tb/tb_aes_host_if.sv
// Bench for aes_host_if: a stand-in AES core driven by the DUT strobes, a
// frame-level reference model, a table of directed frames and random frames.
module tb_aes_host_if;
    import aes_host_if_pkg::*;

    localparam int OP = 12;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
`ifdef AES_HOST_IF_KEY_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         s_valid = 1'b0;
    logic         s_ready;
    logic [31:0]  s_data = '0;
    logic [1:0]   s_cmd = '0;
    logic         m_valid;
    logic         m_ready = 1'b0;
    logic [31:0]  m_data;
    logic         m_last, busy, err;
    logic         set_key, set_plain_text, set_cipher_text, start_enc, start_dec;
    logic [127:0] key, plain_text_in, cipher_text_in;
    logic [127:0] cipher_text_out = '0;
    logic [127:0] plain_text_out = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    aes_host_if #(.OP_CYCLES(OP)) dut (
        .clk             (clk),
        .reset           (reset),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data          (s_data),
        .s_cmd           (s_cmd),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .busy            (busy),
        .err             (err),
        .set_key         (set_key),
        .set_plain_text  (set_plain_text),
        .set_cipher_text (set_cipher_text),
        .start_enc       (start_enc),
        .start_dec       (start_dec),
        .key             (key),
        .plain_text_in   (plain_text_in),
        .cipher_text_in  (cipher_text_in),
        .cipher_text_out (cipher_text_out),
        .plain_text_out  (plain_text_out)
    );

    // Stand-in cipher: knows the FIPS-197 pair, otherwise a keyed XOR.
    function automatic logic [127:0] fake_core(input int op, input logic [127:0] d,
                                               input logic [127:0] k);
        if (op == 1 && d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        if (op == 2 && d == FIPS_CT && k == FIPS_KEY) return FIPS_PT;
        if (op == 1) return d ^ k ^ {4{32'h9e3779b9}};
        return d ^ k ^ {4{32'h7f4a7c15}};
    endfunction

    // Core model: captures operands on set strobes; after a start the result
    // bus carries junk until OP cycles later, when the real result appears.
    logic [127:0] core_key = '0;
    logic [127:0] core_pt = '0;
    logic [127:0] core_ct = '0;
    int core_op = 0;
    int core_cnt = 0;
    always @(negedge clk) begin
        if (set_key) core_key = key;
        if (set_plain_text) core_pt = plain_text_in;
        if (set_cipher_text) core_ct = cipher_text_in;
        if (start_enc || start_dec) begin
            core_op = start_enc ? 1 : 2;
            core_cnt = OP;
            cipher_text_out = {$urandom, $urandom, $urandom, $urandom};
            plain_text_out = {$urandom, $urandom, $urandom, $urandom};
        end else if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
                if (core_op == 1) cipher_text_out = fake_core(1, core_pt, core_key);
                else plain_text_out = fake_core(2, core_ct, core_key);
            end
        end
    end

    // Frame-level reference: what a frame should do given key history.
    logic [127:0] m_key = '0;
    bit m_key_ok = 1'b0;
    task automatic ref_predict(input logic [1:0] cmd, input logic [127:0] blk,
                               output int es, output int est, output bit eerr,
                               output bit eout, output logic [127:0] edat);
        es = 0; est = 0; eerr = 1'b0; eout = 1'b0; edat = '0;
        case (cmd)
            2'd0: begin es = 1; m_key = blk; m_key_ok = 1'b1; end
            2'd1, 2'd2: begin
                if (GUARD && !m_key_ok) eerr = 1'b1;
                else begin
                    es = (cmd == 2'd1) ? 2 : 3;
                    est = int'(cmd);
                    eout = 1'b1;
                    edat = fake_core(int'(cmd), blk, m_key);
                end
            end
            default: eerr = 1'b1;
        endcase
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!s_ready && n < 40) begin tick(); n++; end
        if (!s_ready) chk("s_ready timeout", s_ready, 1'b1);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (n) begin
            tick();
            chk("rst s_ready", s_ready, 1'b0);
            chk("rst m_valid", m_valid, 1'b0);
            chk("rst busy", busy, 1'b0);
            chk("rst strobes", {set_key, set_plain_text, set_cipher_text, start_enc, start_dec, err}, 6'd0);
            chk("rst m_data", m_data, 32'd0);
            chk("rst m_last", m_last, 1'b0);
            chk("rst block", key, 128'd0);
        end
        reset = 1'b0;
        m_key_ok = 1'b0;
        chk("s_ready in release cycle", s_ready, 1'b0);
        tick();
        chk("s_ready after release", s_ready, 1'b1);
    endtask

    task automatic send_frame(input logic [1:0] cmd, input logic [127:0] blk, input bit gaps,
                              output int t_last);
        t_last = cyc;
        for (int b = 0; b < 4; b++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0; s_data = $urandom; tick();
            end
            s_valid = 1'b1;
            s_data = blk[127 - 32*b -: 32];
            s_cmd = (b == 0) ? cmd : 2'($urandom);
            wait_ready();
            t_last = cyc;
            tick();
        end
        s_valid = 1'b0; s_data = $urandom; s_cmd = 2'($urandom);
    endtask

    // Watches one frame from T+1: strobe timing, err, output stream and stalls.
    // Junk beats are offered whenever s_ready is low; none may be taken.
    task automatic watch_frame(input string tag, input int t_last, input logic [127:0] blk,
                               input int exp_set, input int exp_start, input bit exp_err,
                               input bit exp_out, input logic [127:0] exp_data, input int rmode);
        int nset = 0, nstart = 0, nerr = 0, hs = 0, k = 0, budget = 0;
        int set_cyc = -1, start_cyc = -1, err_cyc = -1, first_mv = -1;
        int set_kind = 0, start_kind = 0;
        logic [127:0] got = '0;
        logic [127:0] key_seen = '0;
        logic [31:0] prev_d = '0;
        bit prev_stall = 1'b0, prev_l = 1'b0, last_bad = 1'b0, done = 1'b0;
        while (!done && budget < OP + 80) begin
            if (m_valid) begin
                case (rmode)
                    0: m_ready = 1'b1;
                    1: m_ready = (k % 4 == 0) || (k % 4 == 3);
                    default: m_ready = ($urandom_range(0, 2) != 0);
                endcase
                k++;
            end else m_ready = 1'b0;
            s_valid = !s_ready && ($urandom_range(0, 1) == 1);
            s_data = $urandom;
            if (set_key | set_plain_text | set_cipher_text) begin
                nset++; set_cyc = cyc;
                set_kind = set_key ? 1 : (set_plain_text ? 2 : 3);
                if (set_key) key_seen = key;
            end
            if (start_enc | start_dec) begin
                nstart++; start_cyc = cyc; start_kind = start_enc ? 1 : 2;
            end
            if (err) begin nerr++; err_cyc = cyc; end
            if (prev_stall) begin
                chk({tag, " stall m_valid"}, m_valid, 1'b1);
                chk({tag, " stall m_data"}, m_data, prev_d);
                chk({tag, " stall m_last"}, m_last, prev_l);
            end
            if (m_valid && first_mv < 0) first_mv = cyc;
            if (cyc == t_last + 2) chk({tag, " s_ready at T+2"}, s_ready, !exp_out);
            if (m_valid && m_ready) begin
                hs++;
                got = {got[95:0], m_data};
                if (m_last != (hs == 4)) last_bad = 1'b1;
            end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
            if (exp_out ? (hs == 4) : (cyc >= t_last + OP + 6)) done = 1'b1;
            tick();
            budget++;
        end
        m_ready = 1'b0;
        s_valid = 1'b0;
        chk({tag, " set count"}, nset, exp_set != 0);
        if (exp_set != 0) begin
            chk({tag, " set kind"}, set_kind, exp_set);
            chk({tag, " set at T+1"}, set_cyc - t_last, 1);
        end
        if (exp_set == 1) chk({tag, " key bus"}, key_seen, blk);
        chk({tag, " start count"}, nstart, exp_start != 0);
        if (exp_start != 0) begin
            chk({tag, " start kind"}, start_kind, exp_start);
            chk({tag, " start at T+2"}, start_cyc - t_last, 2);
        end
        chk({tag, " err count"}, nerr, exp_err);
        if (exp_err) chk({tag, " err at T+1"}, err_cyc - t_last, 1);
        if (exp_out) begin
            chk({tag, " first m_valid"}, first_mv - t_last, OP + 3);
            chk({tag, " beats"}, hs, 4);
            chk({tag, " data"}, got, exp_data);
            chk({tag, " m_last placement"}, last_bad, 1'b0);
            chk({tag, " s_ready after last beat"}, s_ready, 1'b1);
        end else begin
            chk({tag, " no output"}, first_mv, -1);
        end
    endtask

    task automatic run_frame(input string tag, input logic [1:0] cmd, input logic [127:0] blk,
                             input int es, input int est, input bit eerr, input bit eout,
                             input logic [127:0] edat, input int rmode, input bit gaps);
        int t;
        send_frame(cmd, blk, gaps, t);
        watch_frame(tag, t, blk, es, est, eerr, eout, edat, rmode);
    endtask

    typedef struct {
        logic [1:0]   cmd;
        logic [127:0] blk;
        int           rmode;
        int           exp_set;
        int           exp_start;
        bit           exp_err;
        bit           exp_out;
        logic [127:0] exp_data;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int es, est, t, r;
        bit ee, eo, any;
        logic [127:0] ed, blk;
        logic [1:0] cmd;

        // encrypt before any key, then FIPS-197 key / encrypt / decrypt, then reserved
        tbl[0].cmd = 2'd1; tbl[0].blk = 128'h0123456789abcdeffedcba9876543210; tbl[0].rmode = 0;
`ifdef AES_HOST_IF_KEY_GUARD_EN
        tbl[0].exp_set = 0; tbl[0].exp_start = 0; tbl[0].exp_err = 1'b1;
        tbl[0].exp_out = 1'b0; tbl[0].exp_data = '0;
`else
        tbl[0].exp_set = 2; tbl[0].exp_start = 1; tbl[0].exp_err = 1'b0;
        tbl[0].exp_out = 1'b1; tbl[0].exp_data = fake_core(1, tbl[0].blk, '0);
`endif
        tbl[1] = '{cmd: 2'd0, blk: FIPS_KEY, rmode: 0, exp_set: 1, exp_start: 0,
                   exp_err: 1'b0, exp_out: 1'b0, exp_data: '0};
        tbl[2] = '{cmd: 2'd1, blk: FIPS_PT, rmode: 0, exp_set: 2, exp_start: 1,
                   exp_err: 1'b0, exp_out: 1'b1, exp_data: FIPS_CT};
        tbl[3] = '{cmd: 2'd2, blk: FIPS_CT, rmode: 1, exp_set: 3, exp_start: 2,
                   exp_err: 1'b0, exp_out: 1'b1, exp_data: FIPS_PT};
        tbl[4] = '{cmd: 2'd3, blk: 128'hcafef00d0badc0de5555aaaa12121212, rmode: 0, exp_set: 0,
                   exp_start: 0, exp_err: 1'b1, exp_out: 1'b0, exp_data: '0};

        apply_reset(3);

        for (int i = 0; i < 5; i++) begin
            ref_predict(tbl[i].cmd, tbl[i].blk, es, est, ee, eo, ed);
            run_frame($sformatf("vec%0d", i), tbl[i].cmd, tbl[i].blk, tbl[i].exp_set,
                      tbl[i].exp_start, tbl[i].exp_err, tbl[i].exp_out, tbl[i].exp_data,
                      tbl[i].rmode, 1'b0);
        end

        // two beats of an encrypt frame, then reset: nothing of it may survive
        s_valid = 1'b1; s_cmd = 2'd1; s_data = 32'hdeadbeef;
        wait_ready(); tick();
        s_data = 32'hfeedface;
        wait_ready(); tick();
        s_data = 32'h12345678; reset = 1'b1;
        any = 1'b0;
        repeat (3) begin
            tick();
            if (set_key | set_plain_text | set_cipher_text | start_enc | start_dec | err) any = 1'b1;
        end
        reset = 1'b0; s_valid = 1'b0; m_key_ok = 1'b0;
        repeat (OP + 6) begin
            tick();
            if (set_key | set_plain_text | set_cipher_text | start_enc | start_dec | err |
                m_valid | busy) any = 1'b1;
        end
        chk("partial frame dropped", any, 1'b0);
        blk = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        ref_predict(2'd0, blk, es, est, ee, eo, ed);
        run_frame("key after reset", 2'd0, blk, es, est, ee, eo, ed, 0, 1'b0);

        // reset in the middle of WAIT: the in-flight result must be dropped
        send_frame(2'd1, FIPS_PT, 1'b0, t);
        repeat (4) tick();
        chk("mid-wait busy", busy, 1'b1);
        apply_reset(1);
        any = 1'b0;
        repeat (OP + 8) begin
            if (set_key | set_plain_text | set_cipher_text | start_enc | start_dec | err |
                m_valid) any = 1'b1;
            tick();
        end
        chk("mid-wait result dropped", any, 1'b0);

        // random frames against the reference model
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 19);
            cmd = (r < 4) ? 2'd0 : (r < 11) ? 2'd1 : (r < 18) ? 2'd2 : 2'd3;
            blk = {$urandom, $urandom, $urandom, $urandom};
            ref_predict(cmd, blk, es, est, ee, eo, ed);
            run_frame($sformatf("rnd%0d", i), cmd, blk, es, est, ee, eo, ed, 2, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d",
                 n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/aes_host_if.md
# aes_host_if

Word-serial host interface that sits directly upstream of the AES core and feeds it. It accepts 32-bit command frames over a valid/ready stream and packs each 4-beat frame into a 128-bit block. It then drives the core's set/start strobes and waits a fixed operation latency. Finally it returns the 128-bit result as a 4-beat valid/ready output stream. It owns all sequencing, so the core is never started without loaded operands.

## Interface
- OP_CYCLES, 12, cycles from start strobe to result valid on the core outputs; must be ≥1.
- clk  in  1  single clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  32  input word; first beat = block bits [127:96], last beat = [31:0].
- s_cmd  in  2  sampled on the first beat of a frame only: 0 load key, 1 encrypt, 2 decrypt, 3 reserved.
- m_valid  out  1  output beat valid.
- m_ready  in  1  output beat consumed when m_valid && m_ready.
- m_data  out  32  output word, same word order as s_data.
- m_last  out  1  high with the 4th output beat.
- busy  out  1  high when the FSM is not in IDLE.
- err  out  1  one-cycle pulse on a rejected frame.
- set_key, set_plain_text, set_cipher_text  out  1 each  one-cycle load strobes to the core.
- start_enc, start_dec  out  1 each  one-cycle start strobes to the core.
- key, plain_text_in, cipher_text_in  out  128 each  all driven from the shared assembly register.
- cipher_text_out, plain_text_out  in  128 each  result buses from the core.

## Operation
- States are IDLE, LOAD, ISSUE, START, WAIT and UNLOAD.
- IDLE → LOAD on the first accepted beat.
  - s_cmd is latched on that beat.
  - The word shifts into the assembly register, and the beat counter becomes 1.
- LOAD accepts beats until 4 beats have been taken, then goes → ISSUE. s_cmd on beats 2–4 is ignored.
- ISSUE pulses exactly one strobe:
  - set_key for cmd 0;
  - set_plain_text for cmd 1;
  - set_cipher_text for cmd 2.
- After ISSUE:
  - cmd 0 → IDLE; no output is produced.
  - cmd 1/2 → START.
- cmd 3 (reserved): ISSUE pulses err only, with no strobe, then → IDLE.
- START pulses start_enc (cmd 1) or start_dec (cmd 2), loads the wait counter with OP_CYCLES, then → WAIT.
- WAIT decrements the counter each cycle.
  - On the last WAIT cycle, load cipher_text_out (cmd 1) or plain_text_out (cmd 2) into the assembly register.
  - Then → UNLOAD.
- UNLOAD presents assembly bits [127:96] on m_data and shifts left by 32 on each handshake.
  - m_last is high on beat 4.
  - After the 4th handshake → IDLE.
- s_ready = 1 only in IDLE and LOAD. m_valid = 1 only in UNLOAD.
- Counter widths: beat counter 2 bits; wait counter $clog2(OP_CYCLES+1) bits.

## Timing
- Reset values:
  - all strobes, s_ready, m_valid, m_last, busy and err are 0;
  - m_data and the assembly register are all-zero;
  - state is IDLE.
- s_ready rises the cycle after reset deasserts.
- Let T be the cycle in which the 4th input beat is accepted:
  - the set strobe fires at T+1;
  - the start strobe fires at T+2;
  - WAIT spans T+3 … T+2+OP_CYCLES;
  - m_valid first rises at T+3+OP_CYCLES.
- Key load: set_key at T+1, s_ready high again at T+2.
- While m_valid && !m_ready, m_data and m_last hold stable and m_valid does not drop. Stalls may be unbounded.
- s_valid while s_ready=0 is ignored and never buffered.
- Reset mid-frame or mid-operation:
  - the partial frame is discarded;
  - any in-flight result is dropped;
  - no strobe fires after the reset cycle.
- Input and output frames never overlap. A new frame is accepted no earlier than the cycle after the last output handshake.

## Configuration
- AES_HOST_IF_KEY_GUARD_EN defined:
  - A key_loaded flag is cleared by reset and set on a cmd 0 ISSUE.
  - A cmd 1/2 frame received while key_loaded=0 is fully consumed, pulses err in ISSUE, issues no set/start strobe, produces no output, and returns to IDLE.
- Not defined: no flag exists. Encrypt and decrypt proceed regardless of key history.

## Structure
- Package aes_host_if_pkg holds:
  - enum cmd_e (CMD_KEY, CMD_ENC, CMD_DEC, CMD_RSVD);
  - enum state_e (the six states);
  - localparam WORDS_PER_BLOCK = 4 and WORD_W = 32.
- One sub-module is natural: aes_block_shreg, a 128-bit register with shift-in-32 / shift-out-32 and parallel load, used as the assembly register.

## Test plan
- Key frame 00010203, 04050607, 08090a0b, 0c0d0e0f:
  - set_key pulses once at T+1;
  - key = 000102030405060708090a0b0c0d0e0f;
  - no m_valid.
- With that key, encrypt 00112233, 44556677, 8899aabb, ccddeeff:
  - output 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a;
  - m_last on the 4th beat;
  - m_valid first at T+3+OP_CYCLES.
- Decrypt the above ciphertext with m_ready toggling 1,0,0,1:
  - returns 00112233 … ccddeeff;
  - m_data is held during stalls.
- Reserved cmd 3 frame: err pulses once, no strobes fire, and s_ready is back at T+2.
- Reset asserted after 2 input beats, then a full key frame:
  - no strobe fires for the partial frame;
  - the new frame loads correctly.
- With the macro defined, encrypt with no prior key: err pulses, start_enc stays 0, and no output is produced. Without the macro, the same stimulus produces 4 output beats.
